// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and IROM.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch stage of the single-cycle miniCPU: owns the PC, runs the IROM handshake,
// commits the next PC and counts retired instructions; halts on timeout or misalignment.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ifetch_unit_if.master        imem,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    output logic [31:0]          pc,
    output logic [31:0]          pc4,
    input  logic [1:0]           npc_op,
    input  logic [31:0]          imm,
    input  logic [31:0]          alu_c,
    input  logic                 ex_stall,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [31:0]          instret
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BEQ = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] NPC_ALU = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_ALIGN   = 2'b10;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int unsigned       CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]     TCNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] tcnt;
    logic [31:0]   npc;
    logic          misaligned;

    assign pc4 = pc + 32'd4;

    always_comb begin
        npc = pc4;
        case (npc_op)
            NPC_PC4:          npc = pc4;
            NPC_BEQ, NPC_JMP: npc = pc + imm;
            NPC_ALU:          npc = alu_c & 32'hFFFF_FFFE;
            default:          npc = pc4;
        endcase
    end

    assign misaligned = |npc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            inst       <= NOP;
            halt_cause <= CAUSE_NONE;
            instret    <= '0;
            tcnt       <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (imem.imem_ack) begin
                        inst  <= imem.imem_rdata;
                        tcnt  <= '0;
                        state <= S_EXEC;
                    end else if (tcnt == TCNT_LAST) begin
                        halt_cause <= CAUSE_TIMEOUT;
                        state      <= S_HALT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!ex_stall) begin
                        if (misaligned) begin
                            halt_cause <= CAUSE_ALIGN;
                            state      <= S_HALT;
                        end else begin
                            pc      <= npc;
                            instret <= instret + 32'd1;
                            state   <= S_FETCH;
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    // Gating with rst drops the request the moment reset is asserted, mid-handshake included.
    assign imem.imem_req  = (state == S_FETCH) && !rst;
    assign imem.imem_addr = pc;
    assign inst_valid     = (state == S_EXEC);
    assign halted         = (state == S_HALT);

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the single-cycle miniCPU. It sits directly upstream of the instruction decoder.
- Owns the PC register and drives the instruction-memory request/acknowledge handshake.
- Presents a stable instruction word to the decoder.
- Computes and commits the next PC from the decoder's npc_op, the sign-extended immediate and the ALU result. It also counts retired instructions and halts on fetch timeout or a misaligned target.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TIMEOUT, 16: maximum cycles spent in FETCH waiting for imem_ack before a fetch-error halt.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; level, held until acknowledged.
- imem_addr  out  32  fetch address; equals pc whenever imem_req=1.
- imem_ack  in  1  instruction word valid on imem_rdata this cycle.
- imem_rdata  in  32  instruction word from IROM.
- inst  out  32  latched instruction word to the decoder.
- inst_valid  out  1  inst is live this cycle (EXEC state).
- pc  out  32  current PC.
- pc4  out  32  pc+4, for write-back of jal/jalr.
- npc_op  in  2  next-PC select from the decoder: 00 PC4, 01 BEQ (pc+imm), 10 JMP (pc+imm), 11 ALU ({alu_c[31:1],1'b0}).
- imm  in  32  sign-extended immediate.
- alu_c  in  32  ALU result, used as the jalr target.
- ex_stall  in  1  hold the current instruction in EXEC.
- halted  out  1  core stopped; cleared only by rst.
- halt_cause  out  2  00 none, 01 fetch timeout, 10 misaligned target.
- instret  out  32  retired-instruction count.

Behaviour:
- Reset (asynchronous, immediate):
  - state=FETCH, pc=RESET_PC, inst=32'h0000_0013 (nop).
  - inst_valid=0, imem_req=0 while rst=1; imem_req asserts in the first cycle after rst falls.
  - halted=0, halt_cause=00, instret=0, timeout counter=0.
  - Reset mid-handshake drops imem_req immediately. Any ack arriving during rst is ignored.
- States: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc, inst_valid=0; the timeout counter increments each cycle.
  - On imem_ack: inst<=imem_rdata, counter<=0, go to EXEC.
  - If the counter reaches TIMEOUT-1 without ack: go to HALT, halt_cause=01.
  - Ack and timeout in the same cycle: ack wins.
- EXEC:
  - imem_req=0, inst_valid=1; inst is held constant.
  - ex_stall=1: remain in EXEC; pc and instret unchanged.
  - ex_stall=0: compute npc from npc_op.
    - npc[1:0]!=0: go to HALT, halt_cause=10, pc unchanged, instret unchanged.
    - Otherwise: pc<=npc, instret<=instret+1, go to FETCH.
- HALT: imem_req=0, inst_valid=0, halted=1; all state frozen until rst.
- Ack outside FETCH is ignored.
- Arithmetic:
  - All 32-bit modulo 2^32. pc+4 and pc+imm wrap silently (0xFFFF_FFFC+4=0).
  - instret wraps from 0xFFFF_FFFF to 0.
- Latency: a zero-wait IROM (ack in the first FETCH cycle) gives 2 cycles per instruction. Each wait cycle adds 1.
- pc4 is combinational from pc. All other outputs are registered or derived only from state.

Test Plan:
- Reset then zero-wait ack with rdata=0x00500093 and npc_op=00:
  - imem_addr=0x0 in cycle 1.
  - EXEC in cycle 2 with inst=0x00500093.
  - pc=0x4 and instret=1 in cycle 3.
- Branch taken: pc=0x10, npc_op=01, imm=0xFFFFFFF8 -> next imem_addr=0x08. Jump: pc=0x08, npc_op=10, imm=0x100 -> pc=0x108.
- JALR: npc_op=11, alu_c=0x0000_0203 -> pc=0x202 (bit0 cleared) -> HALT, halt_cause=10, pc stays at the old value.
- ack withheld for 16 cycles -> halted=1 and halt_cause=01 after exactly 16 FETCH cycles. An ack on cycle 16 instead proceeds to EXEC normally.
- ex_stall=1 for 3 EXEC cycles -> inst_valid high for 4 cycles, inst stable, instret increments once.
- rst asserted mid-FETCH with imem_req=1 -> imem_req=0 in the same cycle. After release the fetch restarts at RESET_PC with instret=0.
